// File: rtl/uart_q_pkg.sv
// Shared types and constants for the UART transmit queue: FSM states, status layout, defaults.
package uart_q_pkg;

    localparam int DEPTH_DEF         = 4;
    localparam int START_TIMEOUT_DEF = 4;
    localparam int LEVEL_W           = 4;

    localparam int STATUS_OVF_BIT   = 7;
    localparam int STATUS_LEVEL_LSB = 1;
    localparam int STATUS_BUSY_BIT  = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_tx_queue_if.sv
// CPU-store / transmitter bundle for uart_tx_queue; slave is the queue, master is the CPU+transmitter side.
interface uart_tx_queue_if;
    import uart_q_pkg::*;

    logic               wr_en;
    logic [7:0]         wr_data;
    logic               clr_ovf;
    logic               tx_busy;
    logic               tx_en;
    logic [7:0]         tx_data;
    logic               full;
    logic               empty;
    logic [LEVEL_W-1:0] level;
    logic               ovf;
    logic [7:0]         status;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_busy,
        input  tx_en, tx_data, full, empty, level, ovf, status
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_busy,
        output tx_en, tx_data, full, empty, level, ovf, status
    );

endinterface

// File: rtl/byte_fifo.sv
// Circular-buffer FIFO with registered level/full/empty; head visible combinationally, push/pop take effect on the edge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle; otherwise it is ignored.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int LW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LW-1:0]    level_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        case ({do_push, do_pop})
            2'b10:   level_nxt = level + 1'b1;
            2'b01:   level_nxt = level - 1'b1;
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a serial transmitter: write-to-tx_en is 2 cycles from idle; tx_en is a one-cycle pulse.
// Writes into a full queue are dropped (sticky ovf) unless a byte leaves in the same cycle.
module uart_tx_queue
    import uart_q_pkg::*;
#(
    parameter int DEPTH         = DEPTH_DEF,
    parameter int START_TIMEOUT = START_TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_tx_queue_if.slave bus
);
    localparam int CW = $clog2(START_TIMEOUT) + 1;

    tx_state_t     state;
    tx_state_t     state_nxt;
    logic [CW-1:0] wait_cnt;
    logic [7:0]    head;
    logic [7:0]    tx_data_q;
    logic          ovf_q;
    logic          pop;
    logic          drop;
    logic          busy_any;

    // START is only reachable with a non-empty FIFO, so the pop always succeeds.
    assign pop  = (state == START);
    assign drop = bus.wr_en && bus.full && !pop;

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (8),
        .LW    (LEVEL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (bus.wr_en),
        .push_data (bus.wr_data),
        .pop       (pop),
        .head      (head),
        .full      (bus.full),
        .empty     (bus.empty),
        .level     (bus.level)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (!bus.empty && !bus.tx_busy) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.tx_busy)
                    state_nxt = WAIT_DONE;
                else if (wait_cnt == CW'(START_TIMEOUT - 1))
                    state_nxt = IDLE;
            end
            WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            tx_data_q <= 8'h00;
            ovf_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == WAIT_BUSY) ? wait_cnt + 1'b1 : '0;
            // Latch the head as we enter START so tx_data is stable for the whole pulse and after.
            if (state == IDLE && state_nxt == START) tx_data_q <= head;
            if (drop)             ovf_q <= 1'b1;
            else if (bus.clr_ovf) ovf_q <= 1'b0;
        end
    end

    assign busy_any    = !bus.empty || (state != IDLE) || bus.tx_busy;
    assign bus.tx_en   = (state == START);
    assign bus.tx_data = tx_data_q;
    assign bus.ovf     = ovf_q;

    always_comb begin
        bus.status                                   = 8'h00;
        bus.status[STATUS_OVF_BIT]                   = ovf_q;
        bus.status[STATUS_LEVEL_LSB +: LEVEL_W]      = bus.level;
        bus.status[STATUS_BUSY_BIT]                  = busy_any;
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a simple transmitter model and a tx_en monitor.
module tb_uart_tx_queue;
    import uart_q_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_queue_if bus ();

    uart_tx_queue #(
        .DEPTH         (4),
        .START_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_chk  = 0;
    int         n_pass = 0;
    logic       auto_busy  = 1'b0;
    logic       force_busy = 1'b0;
    logic [7:0] sent_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmitter: in auto mode, busy rises one cycle after tx_en and stays high for 10 cycles.
    initial begin : xmit_model
        int   cnt;
        logic pend;
        cnt  = 0;
        pend = 1'b0;
        bus.tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!auto_busy) begin
                bus.tx_busy = force_busy;
                cnt  = 0;
                pend = 1'b0;
            end else if (pend) begin
                bus.tx_busy = 1'b1;
                cnt  = 10;
                pend = 1'b0;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) bus.tx_busy = 1'b0;
            end else begin
                bus.tx_busy = 1'b0;
            end
            if (auto_busy && bus.tx_en) pend = 1'b1;
        end
    end

    initial begin : tx_monitor
        forever begin
            @(posedge clk);
            #1;
            if (bus.tx_en === 1'b1) sent_q.push_back(bus.tx_data);
        end
    end

    initial begin : main
        int base;
        int guard;
        logic [7:0] exp_order [5];
        exp_order[0] = 8'h01; exp_order[1] = 8'h02; exp_order[2] = 8'h03;
        exp_order[3] = 8'h04; exp_order[4] = 8'h06;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;
        rst_n       = 1'b0;

        // Reset, with a write attempted while reset is held
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 8'h77;
        tick();
        rst_n = 1'b1; bus.wr_en = 1'b0;
        check("rst_level",   32'(bus.level),   0);
        check("rst_empty",   32'(bus.empty),   1);
        check("rst_full",    32'(bus.full),    0);
        check("rst_ovf",     32'(bus.ovf),     0);
        check("rst_tx_en",   32'(bus.tx_en),   0);
        check("rst_tx_data", 32'(bus.tx_data), 0);
        check("rst_status",  32'(bus.status),  0);

        // Single byte, write-to-tx_en latency, busy handshake
        auto_busy = 1'b1;
        base = sent_q.size();
        bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
        tick();
        bus.wr_en = 1'b0;
        check("t1_level_after_wr", 32'(bus.level), 1);
        check("t1_no_early_tx_en", 32'(bus.tx_en), 0);
        tick();
        check("t1_tx_en",   32'(bus.tx_en),   1);
        check("t1_tx_data", 32'(bus.tx_data), 'hA5);
        tick();
        check("t1_popped",  32'(bus.level),   0);
        check("t1_tx_en_1cyc", 32'(bus.tx_en), 0);
        tick(2);
        check("t1_status_busy", 32'(bus.status), 'h01);
        tick(15);
        check("t1_status_idle", 32'(bus.status), 'h00);
        check("t1_count",       32'(sent_q.size()), 32'(base + 1));
        if (sent_q.size() > base) check("t1_byte", 32'(sent_q[base]), 'hA5);

        // Overflow with the transmitter stuck busy
        auto_busy = 1'b0; force_busy = 1'b1;
        base = sent_q.size();
        tick();
        for (int i = 1; i <= 5; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(i);
            tick();
        end
        bus.wr_en = 1'b0;
        check("t2_level",  32'(bus.level),  4);
        check("t2_full",   32'(bus.full),   1);
        check("t2_empty",  32'(bus.empty),  0);
        check("t2_ovf",    32'(bus.ovf),    1);
        check("t2_status", 32'(bus.status), 'h89);
        check("t2_no_tx",  32'(sent_q.size()), 32'(base));
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        check("t2_ovf_clr",       32'(bus.ovf),    0);
        check("t2_status_clr",    32'(bus.status), 'h09);

        // Write into a full FIFO during START, then drain across the pointer wrap
        base = sent_q.size();
        auto_busy = 1'b1;
        tick();
        check("t3_tx_en",   32'(bus.tx_en),   1);
        check("t3_tx_data", 32'(bus.tx_data), 'h01);
        bus.wr_en = 1'b1; bus.wr_data = 8'h06;
        tick();
        bus.wr_en = 1'b0;
        check("t3_level_kept", 32'(bus.level), 4);
        check("t3_full_kept",  32'(bus.full),  1);
        check("t3_ovf_kept",   32'(bus.ovf),   0);
        guard = 0;
        while (sent_q.size() < base + 5 && guard < 150) begin
            tick();
            guard++;
        end
        check("t3_count", 32'(sent_q.size()), 32'(base + 5));
        for (int i = 0; i < 5; i++)
            if (sent_q.size() > base + i)
                check($sformatf("t3_order%0d", i), 32'(sent_q[base + i]), 32'(exp_order[i]));
        tick(15);
        check("t3_level_end",  32'(bus.level),  0);
        check("t3_status_end", 32'(bus.status), 'h00);

        // Start timeout: transmitter never raises busy
        auto_busy = 1'b0; force_busy = 1'b0;
        base = sent_q.size();
        bus.wr_en = 1'b1; bus.wr_data = 8'h11;
        tick();
        bus.wr_data = 8'h22;
        tick();
        bus.wr_en = 1'b0;
        check("t4_tx_en_a",   32'(bus.tx_en),   1);
        check("t4_tx_data_a", 32'(bus.tx_data), 'h11);
        tick(5);
        check("t4_gap", 32'(bus.tx_en), 0);
        tick();
        check("t4_tx_en_b",   32'(bus.tx_en),   1);
        check("t4_tx_data_b", 32'(bus.tx_data), 'h22);
        tick(8);
        check("t4_count", 32'(sent_q.size()), 32'(base + 2));
        if (sent_q.size() >= base + 2) begin
            check("t4_first",  32'(sent_q[base]),     'h11);
            check("t4_second", 32'(sent_q[base + 1]), 'h22);
        end
        check("t4_level", 32'(bus.level), 0);

        // Reset during WAIT_DONE with bytes queued
        auto_busy = 1'b1;
        base = sent_q.size();
        for (int i = 0; i < 4; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'(8'h31 + i);
            tick();
        end
        check("t5_pre_level", 32'(bus.level), 3);
        rst_n = 1'b0; bus.wr_data = 8'h99;
        tick();
        rst_n = 1'b1; bus.wr_en = 1'b0;
        check("t5_level", 32'(bus.level), 0);
        check("t5_empty", 32'(bus.empty), 1);
        check("t5_tx_en", 32'(bus.tx_en), 0);
        check("t5_status_busy_in", 32'(bus.status), 'h01);
        tick(20);
        check("t5_no_tx_after", 32'(sent_q.size()), 32'(base + 1));
        if (sent_q.size() > base) check("t5_first", 32'(sent_q[base]), 'h31);
        bus.wr_en = 1'b1; bus.wr_data = 8'h41;
        tick();
        bus.wr_en = 1'b0;
        tick();
        check("t5_new_tx_en",   32'(bus.tx_en),   1);
        check("t5_new_tx_data", 32'(bus.tx_data), 'h41);
        tick(15);
        check("t5_count_end", 32'(sent_q.size()), 32'(base + 2));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
